// File: rtl/vx_writeback_arb_pkg.sv
// vx_writeback_arb_pkg: shared widths and the per-unit writeback payload struct
package vx_writeback_arb_pkg;
  localparam int UUID_WIDTH    = 44;
  localparam int ISSUE_WIS_W   = 2;
  localparam int SIMD_IDX_W    = 1;
  localparam int SIMD_WIDTH    = 4;
  localparam int PC_BITS       = 30;
  localparam int NUM_REGS_BITS = 6;
  localparam int XLEN          = 32;
  localparam int NUM_EX_UNITS  = 4;
  typedef struct packed {
    logic [UUID_WIDTH-1:0]              uuid;
    logic [ISSUE_WIS_W-1:0]             wis;
    logic [SIMD_IDX_W-1:0]              sid;
    logic [SIMD_WIDTH-1:0]              tmask;
    logic [PC_BITS-1:0]                 PC;
    logic                               wb;
    logic [NUM_REGS_BITS-1:0]           rd;
    logic [SIMD_WIDTH-1:0][XLEN-1:0]    data;
    logic                               sop;
    logic                               eop;
  } wb_result_t;
  function automatic int popcount(input logic [SIMD_WIDTH-1:0] m);
    return $countones(m);
  endfunction
endpackage

// File: rtl/vx_writeback_arb_if.sv
// vx_writeback_arb_if: execute-unit result inputs and the registered writeback stream
interface vx_writeback_arb_if import vx_writeback_arb_pkg::*; #(
  parameter int NUM_UNITS = NUM_EX_UNITS
);
  logic [NUM_UNITS-1:0]             result_valid;
  wb_result_t [NUM_UNITS-1:0]       result;
  logic [NUM_UNITS-1:0]             result_ready;
  logic                             writeback_valid;
  wb_result_t                       writeback;
  modport master (
    output result_valid, result,
    input  result_ready, writeback_valid, writeback
  );
  modport slave (
    input  result_valid, result,
    output result_ready, writeback_valid, writeback
  );
endinterface

// File: rtl/vx_writeback_arb_rr.sv
// vx_rr_lock_arb: round-robin arbiter with a lock override; pointer advances only on unlock
module vx_rr_lock_arb #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  input  logic          lock,
  input  logic [IW-1:0] lock_idx,
  input  logic          unlock,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  always_comb begin
    found = 1'b0;
    grant_index = '0;
    grant_onehot = '0;
    if (lock) begin
      found = valid[lock_idx];
      grant_index = lock_idx;
    end else begin
      for (int k = 0; k < N; k++)
        if (!found && valid[IW'((int'(ptr_q) + k) % N)]) begin
          found = 1'b1;
          grant_index = IW'((int'(ptr_q) + k) % N);
        end
    end
    for (int i = 0; i < N; i++) grant_onehot[i] = found && grant_index == IW'(i);
  end
  // kept apart from the grant logic so unlock (derived from the grant) forms no loop
  assign ptr_d = unlock ? IW'((int'(grant_index) + 1) % N) : ptr_q;
  always_ff @(posedge clk)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/vx_writeback_arb.sv
// vx_writeback_arb: arbitrates execute-unit results into one registered writeback stream
module vx_writeback_arb import vx_writeback_arb_pkg::*; #(
  parameter int NUM_UNITS  = NUM_EX_UNITS,
  parameter int PERF_CTR_W = 44
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_writeback_arb_if.slave     ifc,
  output logic [PERF_CTR_W-1:0] commit_instrs,
  output logic [PERF_CTR_W-1:0] commit_threads
);
  localparam int IW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  logic [NUM_UNITS-1:0]  grant;
  logic [IW-1:0]         gidx;
  wb_result_t            sel;
  logic                  fire;
  logic                  lock_q, lock_d;
  logic [IW-1:0]         lidx_q, lidx_d;
  logic                  wbv_q, wbv_d;
  wb_result_t            wb_q, wb_d;
  logic [PERF_CTR_W-1:0] instrs_q, instrs_d, threads_q, threads_d;
  vx_rr_lock_arb #(.N(NUM_UNITS)) u_arb (
    .clk(clk), .reset(reset), .valid(ifc.result_valid), .lock(lock_q), .lock_idx(lidx_q),
    .unlock(fire && sel.eop), .grant_onehot(grant), .grant_index(gidx)
  );
  assign sel  = ifc.result[gidx];
  assign fire = |grant;
  always_comb begin
    lock_d    = fire ? !sel.eop : lock_q;
    lidx_d    = fire && !sel.eop ? gidx : lidx_q;
    wbv_d     = fire && sel.wb;
    wb_d      = fire ? sel : wb_q;
    threads_d = threads_q + (fire ? PERF_CTR_W'(popcount(sel.tmask)) : '0);
    instrs_d  = instrs_q + PERF_CTR_W'(fire && sel.eop);
  end
  always_ff @(posedge clk)
    if (reset) begin
      lock_q    <= 1'b0;
      lidx_q    <= '0;
      wbv_q     <= 1'b0;
      wb_q      <= '0;
      instrs_q  <= '0;
      threads_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lidx_q    <= lidx_d;
      wbv_q     <= wbv_d;
      wb_q      <= wb_d;
      instrs_q  <= instrs_d;
      threads_q <= threads_d;
    end
  assign ifc.result_ready    = grant;
  assign ifc.writeback_valid = wbv_q;
  assign ifc.writeback       = wb_q;
  assign commit_instrs       = instrs_q;
  assign commit_threads      = threads_q;
  // a locked unit must continue its instruction, never start a new one
  a_no_sop_while_locked: assert property (@(posedge clk) disable iff (reset)
    !(lock_q && ifc.result_valid[lidx_q] && ifc.result[lidx_q].sop));
endmodule

// File: tb/tb_vx_writeback_arb.sv
// tb_vx_writeback_arb: directed vectors with hand-computed grants, payloads and counters
module tb_vx_writeback_arb;
  import vx_writeback_arb_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [43:0] commit_instrs, commit_threads;
  int          n_chk = 0, n_fail = 0;
  vx_writeback_arb_if ifc ();
  vx_writeback_arb dut (
    .clk(clk), .reset(reset), .ifc(ifc),
    .commit_instrs(commit_instrs), .commit_threads(commit_threads)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ifc.result_valid = '0;
  endtask
  task automatic pkt(input int u, input logic [3:0] tm, input logic wbb, input logic [5:0] rd,
                     input logic sid, input logic sop, input logic eop);
    wb_result_t p;
    p = '0;
    p.uuid = 44'(100 + u);
    p.wis = 2'(u);
    p.sid = sid;
    p.tmask = tm;
    p.PC = 30'h100 + 30'(u);
    p.wb = wbb;
    p.rd = rd;
    p.data = {4{32'hA0 + 32'(u)}};
    p.sop = sop;
    p.eop = eop;
    ifc.result[u] = p;
    ifc.result_valid[u] = 1'b1;
  endtask
  logic [3:0] t2_g [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [5:0] t2_rd[5] = '{6'd13, 6'd10, 6'd11, 6'd13, 6'd10};
  initial begin
    ifc.result_valid = '0;
    ifc.result = '0;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_wbv", ifc.writeback_valid, 0);
    chk("rst_rd", ifc.writeback.rd, 0);
    chk("rst_instrs", commit_instrs, 0);
    chk("rst_threads", commit_threads, 0);
    chk("rst_ready", ifc.result_ready, 0);
    // single packet from unit 2
    pkt(2, 4'b1011, 1, 5, 0, 1, 1);
    #1 chk("t1_ready", ifc.result_ready, 4'b0100);
    step(); idle();
    chk("t1_wbv", ifc.writeback_valid, 1);
    chk("t1_rd", ifc.writeback.rd, 5);
    chk("t1_instrs", commit_instrs, 1);
    chk("t1_threads", commit_threads, 3);
    step();
    chk("idle_wbv", ifc.writeback_valid, 0);
    chk("idle_instrs", commit_instrs, 1);
    // round robin across 0,1,3 starting from pointer 3
    pkt(0, 4'hF, 1, 10, 0, 1, 1);
    pkt(1, 4'hF, 1, 11, 0, 1, 1);
    pkt(3, 4'hF, 1, 13, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("t2_ready%0d", i), ifc.result_ready, t2_g[i]);
      step();
      chk($sformatf("t2_wbv%0d", i), ifc.writeback_valid, 1);
      chk($sformatf("t2_rd%0d", i), ifc.writeback.rd, t2_rd[i]);
    end
    idle();
    chk("t2_instrs", commit_instrs, 6);
    chk("t2_threads", commit_threads, 23);
    // two-packet instruction on unit 1 stays contiguous against unit 0
    pkt(0, 4'hF, 1, 10, 0, 1, 1);
    pkt(1, 4'b0011, 1, 7, 0, 1, 0);
    #1 chk("t3_ready_sop", ifc.result_ready, 4'b0010);
    step();
    chk("t3_sid0", ifc.writeback.sid, 0);
    chk("t3_rd0", ifc.writeback.rd, 7);
    pkt(1, 4'b1100, 1, 7, 1, 0, 1);
    #1 chk("t3_ready_eop", ifc.result_ready, 4'b0010);
    step();
    ifc.result_valid[1] = 1'b0;
    chk("t3_sid1", ifc.writeback.sid, 1);
    chk("t3_instrs1", commit_instrs, 7);
    chk("t3_threads1", commit_threads, 27);
    #1 chk("t3_ready_u0", ifc.result_ready, 4'b0001);
    step(); idle();
    chk("t3_rd_u0", ifc.writeback.rd, 10);
    chk("t3_instrs2", commit_instrs, 8);
    chk("t3_threads2", commit_threads, 31);
    // lock held while unit 1 idles between packets
    pkt(1, 4'b0001, 1, 20, 0, 1, 0);
    pkt(2, 4'hF, 1, 12, 0, 1, 1);
    #1 chk("t4_ready_sop", ifc.result_ready, 4'b0010);
    step();
    ifc.result_valid[1] = 1'b0;
    chk("t4_rd_sop", ifc.writeback.rd, 20);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t4_held%0d", k), ifc.result_ready, 0);
      step();
      chk($sformatf("t4_wbv_held%0d", k), ifc.writeback_valid, 0);
    end
    pkt(1, 4'b0001, 1, 20, 1, 0, 1);
    #1 chk("t4_ready_eop", ifc.result_ready, 4'b0010);
    step();
    ifc.result_valid[1] = 1'b0;
    chk("t4_sid_eop", ifc.writeback.sid, 1);
    #1 chk("t4_ready_u2", ifc.result_ready, 4'b0100);
    step(); idle();
    chk("t4_rd_u2", ifc.writeback.rd, 12);
    chk("t4_instrs", commit_instrs, 10);
    chk("t4_threads", commit_threads, 37);
    // wb=0 packet is consumed and counted without a strobe
    pkt(3, 4'b0111, 0, 9, 0, 1, 1);
    #1 chk("t5_ready", ifc.result_ready, 4'b1000);
    step(); idle();
    chk("t5_wbv", ifc.writeback_valid, 0);
    chk("t5_rd", ifc.writeback.rd, 9);
    chk("t5_instrs", commit_instrs, 11);
    chk("t5_threads", commit_threads, 40);
    // reset while locked on unit 2
    pkt(2, 4'b0011, 1, 22, 0, 1, 0);
    #1 chk("t6_ready_u2", ifc.result_ready, 4'b0100);
    step(); idle();
    reset = 1'b1;
    chk("t6_rd_u2", ifc.writeback.rd, 22);
    step();
    reset = 1'b0;
    chk("t6_wbv", ifc.writeback_valid, 0);
    chk("t6_instrs", commit_instrs, 0);
    chk("t6_threads", commit_threads, 0);
    chk("t6_rd", ifc.writeback.rd, 0);
    pkt(0, 4'hF, 1, 10, 0, 1, 1);
    pkt(2, 4'b0011, 1, 22, 1, 0, 1);
    #1 chk("t6_unit0_first", ifc.result_ready, 4'b0001);
    step(); idle();
    chk("t6_rd_u0", ifc.writeback.rd, 10);
    chk("t6_instrs_after", commit_instrs, 1);
    chk("t6_threads_after", commit_threads, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
